bcd_chain_counter: RTL
======================

# bcd_chain_counter

Parametrised multi-digit modulo counter for the timer/display path: DIGITS cascaded 4-bit digits, each counting 0..MOD-1, default two-digit decimal 00..99. It adds count enable, up/down direction, synchronous clear, parallel load with digit validation, and registered wrap and terminal-count flags. It is the drop-in generalisation of the single-digit mod-10 counter and feeds 7-segment decoders and cascaded timers.

## Interface
- DIGITS, 2, number of 4-bit digits; legal 1..8
- MOD, 10, per-digit modulus; legal 2..16
- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  count enable; one step per cycle while high
- up  in  1  direction: 1 = increment, 0 = decrement; sampled each enabled cycle
- clr  in  1  synchronous clear to all-zero
- load  in  1  synchronous parallel load of load_val
- load_val  in  4*DIGITS  load value; digit i at bits [4i+3:4i], digit 0 least significant
- cnt  out  4*DIGITS  current count, same digit packing as load_val
- tc  out  1  terminal count, combinational from cnt: all digits MOD-1 when up=1, all digits 0 when up=0
- wrap  out  1  registered one-cycle pulse; high in the cycle cnt first shows a wrapped value
- load_err  out  1  registered one-cycle pulse; high in the cycle after a load that contained an out-of-range digit

## Operation
- Reset (rstn low, asynchronous): cnt=0, wrap=0, load_err=0. tc then follows cnt: tc=1 if up=0, else 0.
- Per-cycle priority: clr > load > en > hold.
- clr: cnt <= 0; wrap <= 0; load_err <= 0.
- load: each digit d of load_val is stored as d if d <= MOD-1, otherwise as 0. load_err <= 1 if any digit was out of range, else 0. wrap <= 0.
- en with up=1:
  - digit 0 increments.
  - digit i>0 increments only when every lower digit equals MOD-1.
  - a digit at MOD-1 that increments goes to 0.
  - all digits at MOD-1 -> cnt becomes all zero, wrap <= 1.
- en with up=0:
  - digit 0 decrements.
  - digit i>0 decrements only when every lower digit equals 0.
  - a digit at 0 that decrements goes to MOD-1.
  - all digits zero -> cnt becomes all digits MOD-1, wrap <= 1.
- hold (en=0, no clr/load): cnt unchanged; wrap <= 0; load_err <= 0.
- Direction may change on any cycle. The step taken uses the up value sampled at that edge.
- cnt digits never hold a value >= MOD, whatever the input sequence.
- Digit arithmetic is 4 bits wide. The modulo compare is against the constant MOD-1, so no intermediate value wider than 4 bits is used.

## Timing
- All state changes on posedge clk, except the asynchronous reset.
- Latency: cnt reflects clr/load/en one cycle after the sampling edge.
- wrap and load_err are aligned with the cnt update they describe and last exactly one cycle unless the triggering condition repeats.
- Back-to-back wrap: with MOD=2, DIGITS=1 and en held high, wrap asserts every other cycle.
- tc is combinational. With en=1, tc=1 at an edge means wrap=1 in the next cycle.
- Simultaneous clr+load+en: clr wins and no wrap is produced. Simultaneous load+en: load wins and no step is taken that cycle.
- Reset mid-count: cnt returns to 0 immediately, and any wrap/load_err pulse is cancelled.
- Reset release: the first count occurs at the first posedge where rstn is high and en=1.

## Test plan
- DIGITS=2, MOD=10, reset then en=1, up=1 for 100 cycles -> cnt steps 0x00..0x99 in BCD. At cycle 100 cnt=0x00, wrap=1 for one cycle, and tc=1 while cnt=0x99.
- Set up=0 from cnt=0x00 with en=1 -> cnt=0x99 and wrap=1. Next cycle cnt=0x98, wrap=0. Verify the borrow chain at 0x90->0x89.
- load=1, load_val=0x3C -> cnt=0x30, load_err=1 for one cycle. Then load_val=0x47 -> cnt=0x47, load_err=0.
- At cnt=0x55, assert clr, load and en together -> cnt=0x00, wrap=0. Next, load and en together with load_val=0x12 -> cnt=0x12, no increment that cycle.
- Pull rstn low asynchronously mid-cycle at cnt=0x99 with en=1 -> cnt=0 before the next edge and no wrap pulse. After release, counting resumes 0x01, 0x02, …
- DIGITS=3, MOD=16, up=1 from 0xFFE -> 0xFFF, then 0x000 with wrap=1. MOD=6, DIGITS=1 counts 0..5 and wraps.

Source files
------------

// File: rtl/bcd_chain_counter.sv
// Cascaded modulo-MOD digit counter (default two-digit BCD 00..99)
// with clear, validated parallel load, up/down and wrap/tc flags.
module bcd_chain_counter #(
    parameter int DIGITS = 2,
    parameter int MOD    = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    localparam logic [3:0] MAXD = 4'(MOD - 1);

    logic [DIGITS-1:0]   is_max;
    logic [DIGITS-1:0]   is_zero;
    logic [DIGITS-1:0]   bad;
    logic [DIGITS:0]     cup;
    logic [DIGITS:0]     cdn;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] ld_val;
    logic [3:0]          d;
    logic [3:0]          v;

    // cup/cdn[i]: every digit below i sits at its roll-over value
    always_comb begin
        is_max   = '0;
        is_zero  = '0;
        bad      = '0;
        cup      = '0;
        cdn      = '0;
        step_val = '0;
        ld_val   = '0;
        d        = '0;
        v        = '0;
        cup[0]   = 1'b1;
        cdn[0]   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d          = cnt[4*i +: 4];
            v          = load_val[4*i +: 4];
            is_max[i]  = (d == MAXD);
            is_zero[i] = (d == 4'd0);
            cup[i+1]   = cup[i] & is_max[i];
            cdn[i+1]   = cdn[i] & is_zero[i];
            if (up) begin
                if (cup[i])
                    step_val[4*i +: 4] = is_max[i] ? 4'd0 : d + 4'd1;
                else
                    step_val[4*i +: 4] = d;
            end else begin
                if (cdn[i])
                    step_val[4*i +: 4] = is_zero[i] ? MAXD : d - 4'd1;
                else
                    step_val[4*i +: 4] = d;
            end
            bad[i]           = (v > MAXD);
            ld_val[4*i +: 4] = bad[i] ? 4'd0 : v;
        end
    end

    assign tc = up ? cup[DIGITS] : cdn[DIGITS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (clr) begin
            cnt      <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            cnt      <= ld_val;
            wrap     <= 1'b0;
            load_err <= |bad;
        end else if (en) begin
            cnt      <= step_val;
            wrap     <= tc;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule
